// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the RISC-V front end.
//   XLEN             - machine word width in bits
//   DEFAULT_RESET_PC - byte PC loaded when the core leaves reset
//   fetch_state_t    - fetch unit control states (IDLE, FETCH, FAULT)
//   pc_fetchable()   - true when a byte PC is word aligned and inside
//                      an instruction memory of the given depth
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // A PC can be fetched only if it names a whole word and that word
  // exists in memory; the word index is the PC with its byte offset dropped.
  function automatic logic pc_fetchable(input logic [XLEN-1:0] pc,
                                        input int unsigned     depth);
    logic [XLEN-1:0] word_idx;
    word_idx = {2'b00, pc[XLEN-1:2]};
    return (pc[1:0] == 2'b00) && (word_idx < depth);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if
// Bundles every bus the fetch unit talks on:
//   imem_addr / imem_rd_en / imem_instr        - instruction memory read port
//   redirect_valid / redirect_pc               - branch/jump PC redirect
//   out_valid / out_ready / out_instr / out_pc - handshake towards decode
//   fault                                      - sticky bad-PC indication
// Modports:
//   master - the fetch unit itself
//   slave  - its environment (memory, branch resolution, decode)
interface instr_fetch_if;

  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_instr;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        fault;

  modport master (
    output imem_addr,
    output imem_rd_en,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output fault
  );

  modport slave (
    input  imem_addr,
    input  imem_rd_en,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  fault
  );

endinterface

// File: rtl/instr_fetch.sv
// instr_fetch
// Instruction fetch unit: owns the PC, reads the instruction memory one
// word per cycle, registers the returned instruction and offers it to
// decode over a valid/ready handshake. Redirects from branch resolution
// reload the PC; a misaligned or out-of-range PC halts fetch with a
// sticky fault that only a redirect to a good target clears.
// Parameters:
//   RESET_PC   - byte PC loaded on reset (4-byte aligned)
//   IMEM_DEPTH - instruction memory depth in 32-bit words
// Ports:
//   clk  - clock (memory reads on the falling edge, this block on the rising)
//   rst  - asynchronous active-high reset
//   bus  - instr_fetch_if master: memory port, redirect, decode handshake, fault
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned     IMEM_DEPTH = 1024
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  fetch_state_t    state_q;
  fetch_state_t    state_d;
  logic [XLEN-1:0] pc_q;
  logic            out_valid_q;
  logic [XLEN-1:0] out_instr_q;
  logic [XLEN-1:0] out_pc_q;

  logic            pc_ok;
  logic            target_ok;
  logic            stalled;
  logic            rd_en;

  // Legality of the current PC and of a redirect target, plus the
  // condition where decode is refusing a held instruction.
  always_comb begin
    pc_ok     = pc_fetchable(pc_q, IMEM_DEPTH);
    target_ok = pc_fetchable(bus.redirect_pc, IMEM_DEPTH);
    stalled   = out_valid_q && !bus.out_ready;
  end

  // State register. Reset drops straight back to IDLE so the first cycle
  // after release never issues a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A redirect wins in every state and lands in FETCH
  // or FAULT depending on the target. A bad PC in FETCH only faults once
  // decode has taken whatever instruction is still being held, so a valid
  // instruction is never lost to the fault.
  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid) begin
      state_d = target_ok ? FETCH : FAULT;
    end else begin
      case (state_q)
        IDLE:    state_d = FETCH;
        FETCH:   if (!pc_ok && !stalled) state_d = FAULT;
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic. The read enable is combinational so a stall or redirect
  // suppresses the read in the same cycle; the address comes straight
  // from the PC register.
  always_comb begin
    rd_en          = (state_q == FETCH) && !bus.redirect_valid && !stalled && pc_ok;
    bus.imem_rd_en = rd_en;
    bus.imem_addr  = {2'b00, pc_q[XLEN-1:2]};
    bus.fault      = (state_q == FAULT);
    bus.out_valid  = out_valid_q;
    bus.out_instr  = out_instr_q;
    bus.out_pc     = out_pc_q;
  end

  // PC and output register. A redirect discards any capture that cycle;
  // otherwise a read issued this cycle is captured at the edge and the PC
  // steps by one word. An accepted instruction with nothing behind it
  // simply empties the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else if (bus.redirect_valid) begin
      pc_q        <= bus.redirect_pc;
      out_valid_q <= 1'b0;
    end else if (rd_en) begin
      out_instr_q <= bus.imem_instr;
      out_pc_q    <= pc_q;
      out_valid_q <= 1'b1;
      pc_q        <= pc_q + 32'd4;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
// Directed bench for instr_fetch. A falling-edge instruction memory holds
// word i = (i+1)*0x11. Stimulus pushes the {pc, instr} pairs decode should
// accept into a scoreboard queue; a monitor on the falling edge pops and
// compares every accepted handshake. Cycle-level expectations (latency,
// stall hold, bubble, fault, async reset) are checked inline.
module tb_instr_fetch;

  localparam int DEPTH = 1024;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic rst;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] mem [0:DEPTH-1];
  exp_t        sb_q [$];
  int          tests;
  int          fails;

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: fills with a recognisable pattern and answers a
  // read on the falling edge of the cycle the read enable is high.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = (i + 1) * 32'h11;
  end

  always @(negedge clk) begin
    if (bus.imem_rd_en) bus.imem_instr <= mem[bus.imem_addr[9:0]];
  end

  // Hard stop in case the sequence itself wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [31:0] w;
    w = (pc >> 2) + 32'd1;
    return w * 32'h11;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = word_at(pc);
    sb_q.push_back(e);
  endtask

  // Drive the redirect/ready inputs for the current cycle and let the
  // combinational read enable settle before any inline check.
  task automatic applyStimulus(input logic rv, input logic [31:0] rpc,
                               input logic rdy);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted handshake must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL sb_unexpected: got pc %h with no expected entry", bus.out_pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("sb_pc", bus.out_pc, e.pc);
        checkOutput("sb_instr", bus.out_instr, e.instr);
      end
    end
  end

  // Main directed sequence.
  initial begin
    logic seen_fault;
    tests = 0;
    fails = 0;
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
    bus.imem_instr     = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_out_instr", bus.out_instr, 32'd0);
    checkOutput("rst_out_pc", bus.out_pc, 32'd0);
    checkOutput("rst_fault", {31'd0, bus.fault}, 32'd0);
    checkOutput("rst_rd_en", {31'd0, bus.imem_rd_en}, 32'd0);
    checkOutput("rst_addr", bus.imem_addr, 32'd0);

    // Reset release: IDLE cycle, then fetch of pc 0, then valid.
    pushExpected(32'h0);
    pushExpected(32'h4);
    pushExpected(32'h8);
    pushExpected(32'hC);
    pushExpected(32'h10);
    pushExpected(32'h40);
    pushExpected(32'h44);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("idle_rd_en", {31'd0, bus.imem_rd_en}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t1_rd_en", {31'd0, bus.imem_rd_en}, 32'd1);
    checkOutput("t1_out_valid", {31'd0, bus.out_valid}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t2_out_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("t2_out_pc", bus.out_pc, 32'h0);
    checkOutput("t2_out_instr", bus.out_instr, 32'h11);
    nextCycle();

    // Stall three cycles while pc 4 is held.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("stall_out_pc", bus.out_pc, 32'h4);
      checkOutput("stall_out_instr", bus.out_instr, 32'h22);
      checkOutput("stall_rd_en", {31'd0, bus.imem_rd_en}, 32'd0);
      checkOutput("stall_addr", bus.imem_addr, 32'd2);
      nextCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("release_rd_en", {31'd0, bus.imem_rd_en}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("release_out_pc", bus.out_pc, 32'h8);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    nextCycle();

    // Redirect to 0x40 while pc 0x10 is being accepted.
    applyStimulus(1'b1, 32'h40, 1'b1);
    checkOutput("redir_rd_en", {31'd0, bus.imem_rd_en}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("bubble_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("bubble_addr", bus.imem_addr, 32'h10);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("redir_out_pc", bus.out_pc, 32'h40);
    checkOutput("redir_out_instr", bus.out_instr, 32'h121);
    nextCycle();

    // Misaligned redirect while pc 0x44 is being accepted.
    applyStimulus(1'b1, 32'h42, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("misal_fault", {31'd0, bus.fault}, 32'd1);
    checkOutput("misal_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("misal_rd_en", {31'd0, bus.imem_rd_en}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("misal_fault_sticky", {31'd0, bus.fault}, 32'd1);
    nextCycle();

    // Recover at 0 and run sequentially off the end of memory.
    for (int i = 0; i < DEPTH; i++) pushExpected(32'(i * 4));
    applyStimulus(1'b1, 32'h0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("recover_fault", {31'd0, bus.fault}, 32'd0);
    checkOutput("recover_rd_en", {31'd0, bus.imem_rd_en}, 32'd1);
    checkOutput("recover_addr", bus.imem_addr, 32'd0);
    seen_fault = 1'b0;
    for (int i = 0; i < 1100 && !seen_fault; i++) begin
      nextCycle();
      seen_fault = bus.fault;
    end
    checkOutput("end_fault", {31'd0, bus.fault}, 32'd1);
    checkOutput("end_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("end_rd_en", {31'd0, bus.imem_rd_en}, 32'd0);
    checkOutput("end_sb_empty", sb_q.size(), 32'd0);

    // Stream again, then hit reset asynchronously mid-cycle.
    pushExpected(32'h0);
    pushExpected(32'h4);
    applyStimulus(1'b1, 32'h0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (3) nextCycle();
    checkOutput("pre_rst_addr", bus.imem_addr, 32'd3);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("arst_out_instr", bus.out_instr, 32'd0);
    checkOutput("arst_out_pc", bus.out_pc, 32'd0);
    checkOutput("arst_fault", {31'd0, bus.fault}, 32'd0);
    checkOutput("arst_rd_en", {31'd0, bus.imem_rd_en}, 32'd0);
    checkOutput("arst_addr", bus.imem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("final_sb_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the initiator side of the instruction-memory read port. Holds the program counter, issues word-addressed read requests with a read enable, captures the returned instruction into an output register, and hands it to decode over a valid/ready handshake. It also accepts PC redirects from branch/jump resolution and faults on misaligned or out-of-range PCs.

## Interface
- RESET_PC, 32'h0000_0000, byte PC loaded on reset (must be 4-byte aligned)
- IMEM_DEPTH, 1024, instruction memory depth in 32-bit words
- clk  in  1  clock; memory is read on falling edge, this block on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_addr  out  32  word index to memory = pc >> 2 (pc[31:2] zero-extended)
- imem_rd_en  out  1  read enable to memory
- imem_instr  in  32  instruction from memory; valid after falling edge of the cycle rd_en was high
- redirect_valid  in  1  load redirect_pc this cycle
- redirect_pc  in  32  byte target PC
- out_valid  out  1  out_instr/out_pc hold a fetched instruction
- out_ready  in  1  decode accepts this cycle
- out_instr  out  32  fetched instruction
- out_pc  out  32  byte PC of out_instr
- fault  out  1  fetch halted on bad PC; sticky until valid redirect

## Operation
- States: IDLE (first cycle after reset release, no fetch), FETCH, FAULT.
- IDLE -> FETCH unconditionally next cycle; redirect in IDLE is honoured (pc loads, then FETCH or FAULT per checks).
- In FETCH: imem_rd_en = !redirect_valid && (!out_valid || out_ready) && pc_ok. pc_ok = (pc[1:0]==0) && (pc>>2 < IMEM_DEPTH).
- Rising edge after a cycle with imem_rd_en=1: out_instr <= imem_instr, out_pc <= pc, out_valid <= 1, pc <= pc+4 (32-bit, modular).
- Handshake accepted (out_valid && out_ready) with no new fetch: out_valid <= 0.
- out_valid && !out_ready: out_instr/out_pc/pc held stable, imem_rd_en=0.
- redirect_valid=1 (any state): pc <= redirect_pc, out_valid <= 0, no capture that cycle; a pending accept by decode in the same cycle still counts as consumed. Redirect has priority over fetch and over stall.
- FETCH with !pc_ok and no redirect: -> FAULT, fault <= 1, out_valid <= 0 at next edge (an already-held valid instruction is dropped only after it is accepted; fault asserts when out_valid is 0).
- FAULT: imem_rd_en=0; redirect with aligned, in-range target -> FETCH, fault <= 0; bad target stays in FAULT.
- Memory output is not relied on when imem_rd_en=0.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, out_valid=0, out_instr=0, out_pc=0, fault=0, imem_rd_en=0, imem_addr=RESET_PC>>2.
- Reset is asynchronous; asserting mid-fetch clears all state immediately, in-flight read discarded.
- Latency: PC presented in cycle N -> out_valid=1 from cycle N+1. First out_valid is 2 cycles after reset release (IDLE + fetch cycle).
- Throughput: 1 instruction/cycle while out_ready=1.
- Redirect in cycle N -> target fetched in N+1, out_valid with target instruction in N+2 (1-cycle bubble).
- imem_rd_en is combinational from out_ready and redirect_valid; imem_addr is registered (direct from pc).

## Structure
- Shared package riscv_pkg: XLEN=32, default reset PC constant, fetch_state_t enum {IDLE, FETCH, FAULT}.
- Single module; no sub-module needed (PC register, state register, output register are each a few lines).

## Test plan
- Reset release, out_ready=1, memory words 0..3 = 0x11,0x22,0x33,0x44 -> out_valid from cycle 2, out_pc 0,4,8,C with matching instrs, one per cycle.
- out_ready held 0 for 3 cycles while out_valid=1 at pc=4 -> out_instr/out_pc stable, imem_rd_en=0, no PC advance; release -> pc 8 follows next cycle.
- Redirect to 0x40 while streaming -> one bubble, next valid out_pc=0x40, instr = word 16.
- Redirect to 0x42 -> fault=1 next cycle, out_valid=0, rd_en=0; later redirect to 0x0 -> fault=0, fetch resumes at 0.
- Sequential run to pc=4*IMEM_DEPTH -> last valid out_pc=0xFFC, then fault=1.
- rst asserted mid-stream asynchronously -> all outputs at reset values before next clock edge.
